tpu_sequencer: RTL

//  Control FSM for TOP_tpu. On start it runs num_tiles passes; each pass pops one weight

---
 rtl/tpu_pkg.sv | 21 ++
 rtl/tpu_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU control path: sequencer states and the
// array drain-length helper.
package tpu_pkg;

    // Sequencer phases, in the order a tile passes through them.
    typedef enum logic [2:0] {
        IDLE,
        WFETCH,
        WLOAD,
        STREAM,
        DRAIN,
        DONE
    } seq_state_e;

    // Cycles needed for the last activation row to leave the array.
    // The sum covers the systolic skew plus one cycle of SRAM read latency.
    function automatic int drain_cycles(input int numPeRows, input int matrixSize);
        return numPeRows + matrixSize;
    endfunction

endpackage

// File: rtl/tpu_sequencer.sv
// Control FSM for the TPU top.
// Each tile pops one weight matrix, latches it into the PE array, streams
// MATRIX_SIZE activation rows from SRAM, then waits for the array to drain.
// The host may write SRAM only while the sequencer is idle.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int ADDRESSSIZE = 10,
    parameter int NUM_PE_ROWS = 8,
    parameter int MATRIX_SIZE = 8,
    parameter int TILE_W      = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [TILE_W-1:0]      num_tiles,
    input  logic [ADDRESSSIZE-1:0] act_base,
    output logic                   busy,
    output logic                   end_,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   we_rl,
    input  logic                   host_we,
    input  logic [ADDRESSSIZE-1:0] host_addr,
    output logic                   host_grant,
    output logic                   sram_we,
    output logic                   sram_re,
    output logic [ADDRESSSIZE-1:0] sram_addr,
    output logic                   act_valid
);

    localparam int DRAIN_LEN = drain_cycles(NUM_PE_ROWS, MATRIX_SIZE);
    localparam int ROW_W     = $clog2(MATRIX_SIZE + 1);
    localparam int DRN_W     = $clog2(DRAIN_LEN + 1);

    seq_state_e             state_q, state_d;
    logic [TILE_W-1:0]      tilesLeft_q, tilesLeft_d;
    logic [ADDRESSSIZE-1:0] rdAddr_q, rdAddr_d;
    logic [ROW_W-1:0]       rowCnt_q, rowCnt_d;
    logic [DRN_W-1:0]       drainCnt_q, drainCnt_d;
    logic                   actValid_q;

    // State and counter registers; reset drops any run in progress without a done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            tilesLeft_q <= '0;
            rdAddr_q    <= '0;
            rowCnt_q    <= '0;
            drainCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tilesLeft_q <= tilesLeft_d;
            rdAddr_q    <= rdAddr_d;
            rowCnt_q    <= rowCnt_d;
            drainCnt_q  <= drainCnt_d;
        end
    end

    // Next-state logic; the read address keeps counting across tiles so tile k reads base + k*MATRIX_SIZE.
    always_comb begin
        state_d     = state_q;
        tilesLeft_d = tilesLeft_q;
        rdAddr_d    = rdAddr_q;
        rowCnt_d    = rowCnt_q;
        drainCnt_d  = drainCnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_tiles != '0) begin
                        tilesLeft_d = num_tiles;
                        rdAddr_d    = act_base;
                        state_d     = WFETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WFETCH: begin
                if (!fifo_empty) begin
                    state_d = WLOAD;
                end
            end
            WLOAD: begin
                rowCnt_d = '0;
                state_d  = STREAM;
            end
            STREAM: begin
                rdAddr_d = rdAddr_q + ADDRESSSIZE'(1);
                rowCnt_d = rowCnt_q + ROW_W'(1);
                if (rowCnt_q == ROW_W'(MATRIX_SIZE - 1)) begin
                    drainCnt_d = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (drainCnt_q == DRN_W'(DRAIN_LEN - 1)) begin
                    tilesLeft_d = tilesLeft_q - TILE_W'(1);
                    state_d     = (tilesLeft_q == TILE_W'(1)) ? DONE : WFETCH;
                end else begin
                    drainCnt_d = drainCnt_q + DRN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Row-valid marker trails the read enable by the SRAM's one-cycle latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            actValid_q <= 1'b0;
        end else begin
            actValid_q <= sram_re;
        end
    end

    assign busy       = (state_q != IDLE);
    assign end_       = (state_q == DONE);
    assign fifo_rd_en = (state_q == WFETCH) && !fifo_empty;
    assign we_rl      = (state_q == WLOAD);
    assign sram_re    = (state_q == STREAM);
    assign act_valid  = actValid_q;

    assign host_grant = !busy;
    assign sram_we    = host_we && host_grant;
    assign sram_addr  = busy ? rdAddr_q : host_addr;

endmodule
